// File: rtl/theremin_pkg.sv
// Shared types and elaboration-time helpers for the tone generators.
package theremin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // round(2^(phase_bits+8) / fsamp); the extra 8 bits are dropped after the freq multiply
    function automatic longint inc_k(input int phase_bits, input int fsamp);
        longint num;
        num = longint'(1) << (phase_bits + 8);
        return (num + longint'(fsamp / 2)) / longint'(fsamp);
    endfunction

    // Quarter-wave entry idx: round(max * sin(pi/2 * (idx + 0.5) / 2^lut_bits)).
    // Taylor series in Q30; the half-step offset makes the mirrored quadrants exact.
    function automatic int qw_sine(input int idx, input int lut_bits, input int sig_bits);
        longint x;
        longint term;
        longint sum;
        longint maxv;
        x = (64'sd3373259426 * longint'(2 * idx + 1)) >>> (lut_bits + 2);
        term = x;
        sum  = x;
        for (int k = 1; k <= 7; k++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        maxv = (longint'(1) << (sig_bits - 1)) - 1;
        return int'((sum * maxv + (longint'(1) << 29)) >>> 30);
    endfunction

endpackage

// File: rtl/sine_lut_qw.sv
// Quarter-wave sine lookup: quadrant folding around a magnitude table, one-cycle registered output.
module sine_lut_qw
    import theremin_pkg::*;
#(
    parameter int LUT_BITS = 8,
    parameter int SIG_BITS = 16
)(
    input  logic                       clk,
    input  logic [LUT_BITS+1:0]        i_addr,
    output logic signed [SIG_BITS-1:0] o_sample
);

    localparam int DEPTH = 2 ** LUT_BITS;

    logic [SIG_BITS-2:0]       w_rom [DEPTH];
    logic [1:0]                w_quad;
    logic [LUT_BITS-1:0]       w_idx;
    logic [SIG_BITS-1:0]       w_mag;
    logic signed [SIG_BITS-1:0] r_sample;

    // Table contents are computed at elaboration, so the ROM needs no external file
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam int LP_MAG = qw_sine(gi, LUT_BITS, SIG_BITS);
        assign w_rom[gi] = (SIG_BITS-1)'(LP_MAG);
    end

    assign w_quad = i_addr[LUT_BITS+1:LUT_BITS];
    assign w_idx  = w_quad[0] ? ~i_addr[LUT_BITS-1:0] : i_addr[LUT_BITS-1:0];
    assign w_mag  = {1'b0, w_rom[w_idx]};

    always_ff @(posedge clk) begin
        r_sample <= w_quad[1] ? -w_mag : w_mag;
    end

    assign o_sample = r_sample;

endmodule

// File: rtl/drawbar_synth.sv
// Additive tone generator: N_HARM phase-coherent partials of one fundamental,
// time-multiplexed through a single sine table and summed by one MAC.
module drawbar_synth
    import theremin_pkg::*;
#(
    parameter int F_BITS     = 16,
    parameter int A_BITS     = 4,
    parameter int N_HARM     = 4,
    parameter int SIG_BITS   = 16,
    parameter int PHASE_BITS = 24,
    parameter int LUT_BITS   = 8,
    parameter int FCLK       = 50_000_000,
    parameter int FSAMP      = 192_000
)(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [F_BITS-1:0]          freq,
    input  logic [N_HARM*A_BITS-1:0]   amp,
    output logic signed [SIG_BITS-1:0] out,
    output logic                       out_valid
);

    localparam int DIV    = FCLK / FSAMP;
    localparam int PW     = (clog2(DIV) > 0) ? clog2(DIV) : 1;
    localparam int NH_LOG = clog2(N_HARM);
    localparam int HB     = (NH_LOG > 0) ? NH_LOG : 1;
    localparam int SHIFT  = A_BITS + NH_LOG;
    localparam int ACC_W  = SIG_BITS + SHIFT;
    localparam int PROD_W = F_BITS + 16;
    localparam logic [15:0] INC_K = 16'(inc_k(PHASE_BITS, FSAMP));

    if (DIV < N_HARM + 4) begin : g_rate_check
        $error("drawbar_synth: FCLK/FSAMP must be at least N_HARM+4");
    end

    state_t                     r_state, w_state_next;
    logic [HB-1:0]              r_h, w_h_next;
    logic                       r_drain, w_drain_next;
    logic [PW-1:0]              r_presc;
    logic                       r_tick;
    logic [PHASE_BITS-1:0]      r_inc;
    logic [PHASE_BITS-1:0]      r_phase;
    logic [N_HARM*A_BITS-1:0]   r_amp_q;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_mac_en;
    logic [HB-1:0]              r_mac_h;
    logic signed [SIG_BITS-1:0] r_out;
    logic                       r_out_valid;

    logic [PHASE_BITS-1:0]      w_mult;
    logic [LUT_BITS+1:0]        w_lut_addr;
    logic signed [SIG_BITS-1:0] w_sine;
    logic [A_BITS-1:0]          w_amp_arr [N_HARM];
    logic signed [ACC_W-1:0]    w_sine_ext;
    logic signed [ACC_W-1:0]    w_amp_ext;
    logic signed [ACC_W-1:0]    w_term;

    // Partial h reads the table at phase*(h+1); no per-partial state keeps them coherent
    assign w_mult     = PHASE_BITS'(r_h) + PHASE_BITS'(1);
    assign w_lut_addr = (LUT_BITS+2)'((r_phase * w_mult) >> (PHASE_BITS - LUT_BITS - 2));

    sine_lut_qw #(
        .LUT_BITS (LUT_BITS),
        .SIG_BITS (SIG_BITS)
    ) u_lut (
        .clk      (clk),
        .i_addr   (w_lut_addr),
        .o_sample (w_sine)
    );

    for (genvar gi = 0; gi < N_HARM; gi++) begin : g_amp
        assign w_amp_arr[gi] = r_amp_q[gi*A_BITS +: A_BITS];
    end

    assign w_sine_ext = ACC_W'(w_sine);
    assign w_amp_ext  = $signed(ACC_W'(w_amp_arr[r_mac_h]));
    assign w_term     = w_sine_ext * w_amp_ext;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_h     <= '0;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_h     <= w_h_next;
            r_drain <= w_drain_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_h_next     = r_h;
        w_drain_next = r_drain;
        case (r_state)
            IDLE: begin
                if (r_tick) begin
                    w_state_next = ISSUE;
                    w_h_next     = '0;
                end
            end
            ISSUE: begin
                if (r_h == HB'(N_HARM - 1)) begin
                    w_state_next = DRAIN;
                    w_drain_next = 1'b0;
                end else begin
                    w_h_next = r_h + HB'(1);
                end
            end
            DRAIN: begin
                if (r_drain) w_state_next = DONE;
                else         w_drain_next = 1'b1;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc     <= '0;
            r_tick      <= 1'b0;
            r_inc       <= '0;
            r_phase     <= '0;
            r_amp_q     <= '0;
            r_acc       <= '0;
            r_mac_en    <= 1'b0;
            r_mac_h     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_presc     <= (r_presc == PW'(DIV - 1)) ? '0 : r_presc + PW'(1);
            r_tick      <= (r_presc == PW'(DIV - 1));
            r_inc       <= PHASE_BITS'((PROD_W'(freq) * PROD_W'(INC_K)) >> 8);
            r_mac_en    <= (r_state == ISSUE);
            r_mac_h     <= r_h;
            r_out_valid <= (r_state == DONE);
            if (r_tick) begin
                r_phase <= r_phase + r_inc;
                r_amp_q <= amp;
                r_acc   <= '0;
            end else if (r_mac_en) begin
                r_acc <= r_acc + w_term;
            end
            // The shift divides by the worst-case gain, so the result always fits
            if (r_state == DONE) r_out <= SIG_BITS'(r_acc >>> SHIFT);
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule
